mem_initiator: RTL and testbench

- Core-side master for the single-port word memory.
- Accepts one read or write command at a time over a valid/ready request channel.
- Drives the memory request, read/write select, address and write-data lines, and waits out the memory's read access time.
- Returns a single-cycle response carrying read data or an error flag; sits between the CPU load/store unit and the memory.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/mem_initiator.sv | 115 +++++++++++
 tb/tb_mem_initiator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and default sizes for the word memory interface
package mem_if_pkg;

    // Default geometry, shared with the memory block so both sides agree
    localparam int MemDataWidth = 32;
    localparam int MemAddrWidth = 24;
    localparam int MemWords     = 4096;

    // Width of the read access-time counter (AccessCycles up to 15)
    localparam int WaitW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-command master for the single-port word memory
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             command handshake
//   req_we, req_addr, req_wdata     command: 1 = write, word address, write data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle response, read data, out-of-range flag
//   mem_req, mem_rdwr_bar           memory strobe, 1 = read / 0 = write
//   mem_addr, mem_data_in           address and write data to the memory
//   mem_data_out                    read data from the memory
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int DataWidth    = MemDataWidth,
    parameter int AddrWidth    = MemAddrWidth,
    parameter int Words        = MemWords,
    parameter int AccessCycles = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_req,
    output logic                 mem_rdwr_bar,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_data_in,
    input  logic [DataWidth-1:0] mem_data_out
);

    // One extra bit so Words == 2**AddrWidth still compares correctly
    localparam logic [AddrWidth:0] WordsLimit = (AddrWidth + 1)'(Words);
    localparam logic [WaitW-1:0]   LastCnt    = WaitW'(AccessCycles - 1);

    mem_state_e       state;
    logic [WaitW-1:0] wait_cnt;
    logic             addr_bad;

    assign addr_bad = ({1'b0, req_addr} >= WordsLimit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            mem_req      <= 1'b0;
            mem_rdwr_bar <= 1'b1;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr    <= req_addr;
                        mem_data_in <= req_wdata;
                        req_ready   <= 1'b0;
                        rsp_err     <= 1'b0;
                        if (addr_bad) begin
                            // Rejected without touching the memory bus
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (req_we) begin
                            mem_req      <= 1'b1;
                            mem_rdwr_bar <= 1'b0;
                            state        <= WRITE;
                        end else begin
                            mem_req      <= 1'b1;
                            mem_rdwr_bar <= 1'b1;
                            wait_cnt     <= '0;
                            state        <= READ;
                        end
                    end
                end
                WRITE: begin
                    // Memory commits on the edge that ends the single strobe cycle
                    mem_req      <= 1'b0;
                    mem_rdwr_bar <= 1'b1;
                    rsp_rdata    <= '0;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                READ: begin
                    if (wait_cnt == LastCnt) begin
                        // Data is sampled while mem_req is still high
                        rsp_rdata <= mem_data_out;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - self-checking bench for mem_initiator
module tb_mem_initiator;

    localparam int DW    = 32;
    localparam int AW    = 24;
    localparam int WORDS = 4096;
    localparam int AC    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_req;
    logic          mem_rdwr_bar;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int rsp_cyc  = 0;

    // Memory fixture attached to the bus, and the bench's own expected contents
    logic [DW-1:0] mem     [0:WORDS-1];
    logic [DW-1:0] ref_mem [0:WORDS-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (mem_req && !mem_rdwr_bar && mem_addr < AW'(WORDS))
            mem[mem_addr[11:0]] = mem_data_in;

    assign mem_data_out = (mem_req && mem_rdwr_bar && mem_addr < AW'(WORDS)) ?
                          mem[mem_addr[11:0]] : '0;

    mem_initiator #(
        .DataWidth(DW), .AddrWidth(AW), .Words(WORDS), .AccessCycles(AC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_rdwr_bar(mem_rdwr_bar), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check its full bus and response behaviour
    task automatic do_cmd(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit hold, input string tag);
        int guard, nreq, first_req, rdy_hi, bad_rw, bad_addr, rsp_k, exp_lat, exp_nreq;
        logic [DW-1:0] got_rdata, exp_rdata;
        logic got_err;
        bit err;
        nreq = 0; first_req = -1; rdy_hi = 0; bad_rw = 0; bad_addr = 0; rsp_k = -1;
        got_rdata = '0; got_err = 1'b0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accept_wait"}, 64'(guard < 50), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) req_valid = 1'b0;

        err       = (addr >= AW'(WORDS));
        exp_lat   = err ? 1 : (we ? 2 : AC + 1);
        exp_nreq  = err ? 0 : (we ? 1 : AC);
        exp_rdata = (!we && !err) ? ref_mem[addr[11:0]] : '0;
        if (we && !err) ref_mem[addr[11:0]] = wdata;

        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                if (first_req < 0) first_req = k;
                if (mem_rdwr_bar !== !we) bad_rw++;
                if (mem_addr !== addr) bad_addr++;
            end
            if (req_ready) rdy_hi++;
            if (rsp_valid) begin
                rsp_k = k;
                rsp_cyc = cyc;
                got_rdata = rsp_rdata;
                got_err = rsp_err;
                break;
            end
        end
        check({tag, "_latency"}, 64'(rsp_k), 64'(exp_lat));
        check({tag, "_mem_req_cycles"}, 64'(nreq), 64'(exp_nreq));
        if (exp_nreq > 0) check({tag, "_mem_req_start"}, 64'(first_req), 64'd1);
        check({tag, "_rdwr_sel"}, 64'(bad_rw), 64'd0);
        check({tag, "_mem_addr"}, 64'(bad_addr), 64'd0);
        check({tag, "_ready_busy"}, 64'(rdy_hi), 64'd0);
        check({tag, "_rsp_err"}, 64'(got_err), 64'(err));
        check({tag, "_rsp_rdata"}, 64'(got_rdata), 64'(exp_rdata));
        if (we && !err) check({tag, "_mem_word"}, 64'(mem[addr[11:0]]), 64'(wdata));

        @(negedge clk);
        check({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
        check({tag, "_bus_idle"}, {62'd0, mem_req, mem_rdwr_bar}, 64'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, stray;
        logic we;
        logic [AW-1:0] a;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rdwr_bar", 64'(mem_rdwr_bar), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_data_in", 64'(mem_data_in), 64'd0);

        // Directed: write, read-back, out-of-range, boundary addresses
        do_cmd(1'b1, 24'h000010, 32'hDEADBEEF, 1'b0, "wr16");
        do_cmd(1'b0, 24'h000010, 32'h0, 1'b0, "rd16");
        do_cmd(1'b0, 24'h001000, 32'h0, 1'b0, "rd_oor");
        do_cmd(1'b1, 24'hFFFFFF, 32'h55AA55AA, 1'b0, "wr_oor");
        do_cmd(1'b1, 24'h000FFF, 32'hCAFEF00D, 1'b0, "wr_last");
        do_cmd(1'b0, 24'h000FFF, 32'h0, 1'b0, "rd_last");

        // Back-to-back with req_valid held high throughout
        do_cmd(1'b1, 24'h000020, 32'h12345678, 1'b1, "b2b_wr");
        r1 = rsp_cyc;
        do_cmd(1'b0, 24'h000020, 32'h0, 1'b0, "b2b_rd");
        check("b2b_accept_cycle", 64'(acc_cyc), 64'(r1 + 2));

        // Reset in the first strobe cycle of a read
        req_we = 1'b0; req_addr = 24'h000010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rstmid_mem_req_live", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_mem_req", 64'(mem_req), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd1);
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) stray++;
            @(negedge clk);
        end
        check("rstmid_no_rsp", 64'(stray), 64'd0);
        do_cmd(1'b0, 24'h000010, 32'h0, 1'b0, "rstmid_reread");

        // Randomised traffic against the bench's memory image
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                a = AW'(WORDS) + AW'($urandom_range(0, 200));
            else
                a = AW'($urandom_range(0, 63));
            do_cmd(we, a, $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
